// File: rtl/io_handshake_ctrl.sv
// I/O handshake controller: debounced Enter capture for `in`, timed display hold for `out`.
// Optional IO_OUT_ACK_EN: each `out` additionally waits for an Enter acknowledge.
module io_handshake_ctrl #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned OUT_HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inputctr,
  input  logic              outctr,
  input  logic [SW_W-1:0]   sw_data,
  input  logic              btn_enter,
  input  logic [DATA_W-1:0] out_value,
  output logic              inread,
  output logic [DATA_W-1:0] in_data,
  output logic              outend,
  output logic [DATA_W-1:0] display,
  output logic              busy
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(OUT_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IN_WAIT,
    S_IN_DONE,
    S_OUT_SHOW,
    S_OUT_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
  logic                db_level_q, db_level_d;
  logic                db_prev_q;
  logic                enter_pulse;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]   in_data_q, in_data_d;
  logic [DATA_W-1:0]   display_q, display_d;
  logic                out_release;

`ifdef IO_OUT_ACK_EN
  logic ack_q, ack_d;
  // The acknowledge may arrive before or after the timer expires.
  assign out_release = (hold_cnt_q == '0) && (ack_q || enter_pulse);
`else
  assign out_release = (hold_cnt_q == '0);
`endif

  assign enter_pulse = db_level_q & ~db_prev_q;

  // Debounce: level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      hold_cnt_q <= '0;
      in_data_q  <= '0;
      display_q  <= '0;
`ifdef IO_OUT_ACK_EN
      ack_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= btn_enter;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      hold_cnt_q <= hold_cnt_d;
      in_data_q  <= in_data_d;
      display_q  <= display_d;
`ifdef IO_OUT_ACK_EN
      ack_q      <= ack_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    in_data_d  = in_data_q;
    display_d  = display_q;
`ifdef IO_OUT_ACK_EN
    ack_d      = ack_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (inputctr) begin
          state_d = S_IN_WAIT;
        end else if (outctr) begin
          state_d    = S_OUT_SHOW;
          display_d  = out_value;
          hold_cnt_d = HOLD_W'(OUT_HOLD_CYCLES - 1);
`ifdef IO_OUT_ACK_EN
          ack_d      = 1'b0;
`endif
        end
      end
      S_IN_WAIT: begin
        if (!inputctr) begin
          state_d = S_IDLE;
        end else if (enter_pulse) begin
          state_d   = S_IN_DONE;
          in_data_d = DATA_W'(sw_data);
        end
      end
      S_IN_DONE: state_d = S_IDLE;
      S_OUT_SHOW: begin
`ifdef IO_OUT_ACK_EN
        if (enter_pulse) ack_d = 1'b1;
`endif
        if (!outctr) begin
          state_d = S_IDLE;
        end else if (out_release) begin
          state_d = S_OUT_DONE;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_OUT_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inread  = (state_q == S_IN_DONE);
    outend  = (state_q == S_OUT_DONE);
    busy    = (state_q != S_IDLE);
    in_data = in_data_q;
    display = display_q;
  end

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Directed bench for io_handshake_ctrl; handshake pulses are checked against a scoreboard queue.
module tb_io_handshake_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inputctr = 1'b0;
  logic        outctr = 1'b0;
  logic [15:0] sw_data = '0;
  logic        btn_enter = 1'b0;
  logic [31:0] out_value = '0;
  logic        inread, outend, busy;
  logic [31:0] in_data, display;

  io_handshake_ctrl #(
    .DATA_W(32), .SW_W(16), .DEBOUNCE_CYCLES(D), .OUT_HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inputctr(inputctr), .outctr(outctr),
    .sw_data(sw_data), .btn_enter(btn_enter), .out_value(out_value),
    .inread(inread), .in_data(in_data), .outend(outend),
    .display(display), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_in;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse monitor: every inread/outend must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && (inread || outend)) begin
      chk("pulse_exclusive", {31'b0, inread & outend}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {31'b0, inread}, {31'b0, outend});
        chk("unexpected_pulse_any", 32'd1, {31'b0, 1'b0} );
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {31'b0, inread}, {31'b0, e.is_in});
        chk("pulse_data", e.is_in ? in_data : display, e.data);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, p;
    #12;
    chk("rst_inread", {31'b0, inread}, 32'd0);
    chk("rst_outend", {31'b0, outend}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_data", in_data, 32'd0);
    chk("rst_display", display, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Input capture, held button yields a single pulse
    inputctr = 1'b1;
    sw_data  = 16'hA5C3;
    tick(1);
    chk("in_wait_busy", {31'b0, busy}, 32'd1);
    btn_enter = 1'b1;
    p = cyc;
    q.push_back('{is_in: 1'b1, data: 32'h0000A5C3, cyc: p + D + 3});
    tick(10);
    chk("in_rearm_busy", {31'b0, busy}, 32'd1);
    chk("in_data_held", in_data, 32'h0000A5C3);
    tick(5);
    btn_enter = 1'b0;
    tick(D + 4);

    // Bounce rejection while in IN_WAIT
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      tick(2);
      chk("bounce_busy", {31'b0, busy}, 32'd1);
    end
    tick(D + 4);
    chk("bounce_in_data", in_data, 32'h0000A5C3);
    inputctr = 1'b0;
    tick(1);
    chk("in_abort_idle", {31'b0, busy}, 32'd0);

`ifndef IO_OUT_ACK_EN
    // Output hold: outend H+1 cycles after outctr is presented
    c = cyc;
    outctr    = 1'b1;
    out_value = 32'hDEADBEEF;
    q.push_back('{is_in: 1'b0, data: 32'hDEADBEEF, cyc: c + 1 + H});
    tick(1);
    chk("out_display", display, 32'hDEADBEEF);
    chk("out_busy", {31'b0, busy}, 32'd1);
    tick(H);
    outctr    = 1'b0;
    out_value = 32'h0;
    tick(3);
    chk("out_retained", display, 32'hDEADBEEF);
    chk("out_idle", {31'b0, busy}, 32'd0);
`else
    // Acknowledged output: no release without a press
    outctr    = 1'b1;
    out_value = 32'hDEADBEEF;
    tick(1);
    chk("ack_display", display, 32'hDEADBEEF);
    tick(50);
    chk("ack_waiting", {31'b0, busy}, 32'd1);
    btn_enter = 1'b1;
    p = cyc;
    q.push_back('{is_in: 1'b0, data: 32'hDEADBEEF, cyc: p + D + 3});
    tick(D + 3);
    outctr    = 1'b0;
    out_value = 32'h0;
    tick(2);
    btn_enter = 1'b0;
    tick(D + 4);
    chk("ack_idle", {31'b0, busy}, 32'd0);
    chk("ack_retained", display, 32'hDEADBEEF);
`endif

    // Priority and abort
    inputctr  = 1'b1;
    outctr    = 1'b1;
    out_value = 32'hCAFE0001;
    tick(1);
    chk("prio_busy", {31'b0, busy}, 32'd1);
    chk("prio_display", display, 32'hDEADBEEF);
    tick(2);
    inputctr = 1'b0;
    tick(1);
    chk("prio_abort_idle", {31'b0, busy}, 32'd0);
    tick(1);
    chk("prio_out_display", display, 32'hCAFE0001);
    chk("prio_out_busy", {31'b0, busy}, 32'd1);
    tick(2);
    outctr = 1'b0;
    tick(1);
    chk("out_abort_idle", {31'b0, busy}, 32'd0);
    tick(H + 3);
    chk("out_abort_display", display, 32'hCAFE0001);

    // Asynchronous reset in the middle of OUT_SHOW
    outctr    = 1'b1;
    out_value = 32'h00001234;
    tick(3);
    chk("pre_rst_display", display, 32'h00001234);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_display", display, 32'd0);
    chk("mid_rst_in_data", in_data, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_outend", {31'b0, outend}, 32'd0);
    chk("mid_rst_inread", {31'b0, inread}, 32'd0);
    outctr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);

    tick(5);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
